// File: rtl/if_pc_unit_if.sv
// Fetch-stage PC bus: redirect requests and stalls in, fetch address out.
// The pc unit connects through the slave modport and its driver through the master modport.
interface if_pc_unit_if #(
  parameter int PC_W = 30
);
  logic            hazard;
  logic            BranchBubble;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            jump;
  logic [25:0]     j_index;
  logic [PC_W-1:0] id_pc_plus_4;
  logic            jr;
  logic [PC_W-1:0] jr_target;
  logic            exc;
  logic            eret;
  logic [PC_W-1:0] epc;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus_4;
  logic            redir_pend;

  modport slave (
    input  hazard, BranchBubble, br_taken, br_target, jump, j_index, id_pc_plus_4,
           jr, jr_target, exc, eret, epc,
    output pc, pc_plus_4, redir_pend
  );

  modport master (
    output hazard, BranchBubble, br_taken, br_target, jump, j_index, id_pc_plus_4,
           jr, jr_target, exc, eret, epc,
    input  pc, pc_plus_4, redir_pend
  );
endinterface

// File: rtl/if_pc_unit.sv
// Fetch-stage program counter: next-PC select with redirect priority, and stall handling
// that parks redirects arriving during a stall until the stall releases.
module if_pc_unit #(
  parameter int              PC_W     = 30,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] EXC_PC   = PC_W'(32'h0000_1000)
) (
  input logic         clk,
  input logic         rst_n,
  if_pc_unit_if.slave bus
);
  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] HOLD_RD = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [2:0]      pend_pri_q, pend_pri_d;

  logic            stall;
  logic [2:0]      win_pri;
  logic [PC_W-1:0] win_tgt;
  logic [PC_W-1:0] pc_inc;

  assign stall  = bus.hazard | bus.BranchBubble;
  assign pc_inc = pc_q + 1'b1;

  // Priority code doubles as "any redirect" (nonzero) and as the compare key for pending.
  always_comb begin
    win_pri = 3'd0;
    win_tgt = '0;
    if (bus.exc) begin
      win_pri = 3'd5; win_tgt = EXC_PC;
    end else if (bus.eret) begin
      win_pri = 3'd4; win_tgt = bus.epc;
    end else if (bus.jr) begin
      win_pri = 3'd3; win_tgt = bus.jr_target;
    end else if (bus.jump) begin
      win_pri = 3'd2; win_tgt = {bus.id_pc_plus_4[PC_W-1:PC_W-4], bus.j_index};
    end else if (bus.br_taken) begin
      win_pri = 3'd1; win_tgt = bus.br_target;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_pri_d = pend_pri_q;
    case (state_q)
      HOLD_RD: begin
        if (stall) begin
          if (win_pri > pend_pri_q) begin
            pend_tgt_d = win_tgt;
            pend_pri_d = win_pri;
          end
        end else begin
          // Release never falls through to pc+1: the parked redirect is always honoured.
          pc_d       = (win_pri > pend_pri_q) ? win_tgt : pend_tgt_q;
          pend_tgt_d = '0;
          pend_pri_d = 3'd0;
          state_d    = RUN;
        end
      end
      default: begin
        if (!stall) begin
          pc_d    = (win_pri != 3'd0) ? win_tgt : pc_inc;
          state_d = RUN;
        end else if (win_pri != 3'd0) begin
          pend_tgt_d = win_tgt;
          pend_pri_d = win_pri;
          state_d    = HOLD_RD;
        end else begin
          state_d = HOLD;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pend_tgt_q <= '0;
      pend_pri_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_pri_q <= pend_pri_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus_4  = pc_inc;
  assign bus.redir_pend = (state_q == HOLD_RD);
endmodule
